// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the digit-serial magnitude comparator:
// controller state encoding and the digit-count derivation.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } cmp_state_t;

  // Guarded so an illegal DIGIT of zero still elaborates far enough to hit the parameter check.
  function automatic int calc_ndigits(input int width, input int digit);
    if (digit > 0) begin
      return width / digit;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit slice; exactly one
// output is high for any input pair.
module digit_comparator #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt,
  output logic             o_gt
);

  always_comb begin
    o_eq = 1'b0;
    o_lt = 1'b0;
    o_gt = 1'b0;
    if (i_a == i_b) begin
      o_eq = 1'b1;
    end else if (i_a < i_b) begin
      o_lt = 1'b1;
    end else begin
      o_gt = 1'b1;
    end
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks captured operands MSB digit
// first and stops at the first differing digit.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_equals_b,
  output logic             a_less_than_b,
  output logic             a_greater_than_b
);

  localparam int NDIGITS = calc_ndigits(WIDTH, DIGIT);
  localparam int IDXW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("seq_magnitude_comparator: WIDTH must be a nonzero multiple of DIGIT");
  end

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;

  logic [WIDTH-1:0] w_a_adj;
  logic [WIDTH-1:0] w_b_adj;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic             w_eq;
  logic             w_lt;
  logic             w_gt;
  logic             w_last;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_a_adj = r_a ^ ({WIDTH{r_signed}} & MSB_MASK);
  assign w_b_adj = r_b ^ ({WIDTH{r_signed}} & MSB_MASK);
  assign w_a_dig = w_a_adj[r_idx*DIGIT +: DIGIT];
  assign w_b_dig = w_b_adj[r_idx*DIGIT +: DIGIT];
  assign w_last  = (r_idx == IDXW'(0));

  digit_comparator #(.DIGIT(DIGIT)) u_digit_cmp (
    .i_a  (w_a_dig),
    .i_b  (w_b_dig),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_COMPARE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (!w_eq || w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_COMPARE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_COMPARE);
      r_done  <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= IDXW'(NDIGITS - 1);
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (!w_eq) begin
            r_lt <= w_lt;
            r_gt <= w_gt;
          end else if (w_last) begin
            r_eq <= 1'b1;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign a_equals_b       = r_eq;
  assign a_less_than_b    = r_lt;
  assign a_greater_than_b = r_gt;

endmodule
